// File: rtl/bp_pkg.sv
// Shared definitions for the BTB branch predictor: direction-counter encodings and
// PC index/tag slicing helpers.
package bp_pkg;

    // Encodings for the common 2-bit direction counter.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Weakly-taken: MSB set, all other bits clear.
    function automatic int unsigned weak_t(input int unsigned cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    // Weakly-not-taken: MSB clear, all other bits set.
    function automatic int unsigned weak_nt(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w,
                                           input int unsigned tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a CNT_W-bit saturating up/down counter.
module bp_sat_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    output logic [CNT_W-1:0] nxt
);

    always_comb begin
        nxt = cnt;
        if (inc) begin
            if (cnt != '1) nxt = cnt + 1'b1;
        end else begin
            if (cnt != '0) nxt = cnt - 1'b1;
        end
    end

endmodule

// File: rtl/bp_btb_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, mispredict detection
// and saturating performance counters.
module bp_btb_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] correct_pc,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(weak_t(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(weak_nt(CNT_W));

    // Flop arrays: lookup must be an asynchronous read.
    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];
    logic [CNT_W-1:0]  cnt_q   [ENTRIES];

    logic [PERF_W-1:0] perf_br_q;
    logic [PERF_W-1:0] perf_mis_q;

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [CNT_W-1:0] cnt_nxt;

    assign l_idx = IDX_W'(pc_index(64'(if_pc), IDX_W));
    assign l_tag = TAG_W'(pc_tag(64'(if_pc), IDX_W, TAG_W));
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

    // Forced to not-taken while reset is held so the fetch stream is sane during reset.
    assign pred_taken  = reset && l_hit && cnt_q[l_idx][CNT_W-1];
    assign pred_target = pred_taken ? tgt_q[l_idx] : if_pc + ADDR_W'(4);

    assign u_idx = IDX_W'(pc_index(64'(upd_pc), IDX_W));
    assign u_tag = TAG_W'(pc_tag(64'(upd_pc), IDX_W, TAG_W));
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    bp_sat_counter #(
        .CNT_W(CNT_W)
    ) u_sat_counter (
        .cnt(cnt_q[u_idx]),
        .inc(upd_taken),
        .nxt(cnt_nxt)
    );

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);

    assign perf_branches = perf_br_q;
    assign perf_mispred  = perf_mis_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= CNT_WEAK_NT;
            end
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (upd_valid) begin
                if (u_hit) begin
                    cnt_q[u_idx] <= cnt_nxt;
                    if (upd_taken) tgt_q[u_idx] <= upd_target;
                end else if (upd_taken) begin
                    valid_q[u_idx] <= 1'b1;
                    tag_q[u_idx]   <= u_tag;
                    tgt_q[u_idx]   <= upd_target;
                    cnt_q[u_idx]   <= CNT_WEAK_T;
                end
                if (perf_br_q != '1) perf_br_q <= perf_br_q + 1'b1;
            end
            if (mispredict && (perf_mis_q != '1)) perf_mis_q <= perf_mis_q + 1'b1;
        end
    end

endmodule
